// File: rtl/alu_issue.sv
// Issue stage ahead of the ALU: 2-entry skid buffer (main + skid) with writeback forwarding.
// Optional macro ALU_ISSUE_FWD_EN enables forwarding; without it wb_* are ignored.
module alu_issue #(
    parameter int XLEN   = 32,
    parameter int RIDX_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [RIDX_W-1:0] in_rs1,
    input  logic [RIDX_W-1:0] in_rs2,
    input  logic              in_b_imm,
    input  logic [RIDX_W-1:0] in_rd,
    input  logic [XLEN-1:0]   in_a,
    input  logic [XLEN-1:0]   in_b,
    input  logic              wb_valid,
    input  logic [RIDX_W-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   alu_src_a,
    output logic [XLEN-1:0]   alu_src_b,
    output logic [2:0]        alu_op,
    output logic [RIDX_W-1:0] out_rd
);

`ifdef ALU_ISSUE_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    typedef struct packed {
        logic [2:0]        op;
        logic [RIDX_W-1:0] rs1;
        logic [RIDX_W-1:0] rs2;
        logic              b_imm;
        logic [RIDX_W-1:0] rd;
        logic [XLEN-1:0]   a;
        logic [XLEN-1:0]   b;
    } entry_t;

    entry_t main_q, skid_q;
    entry_t in_e, in_f, main_f, skid_f;
    logic   main_valid, skid_valid;
    logic   accept, fire;

    // Replace any operand whose source register is being written back this edge.
    function automatic entry_t fwd(input entry_t e, input logic wv,
                                   input logic [RIDX_W-1:0] wr, input logic [XLEN-1:0] wd);
        entry_t r;
        r = e;
        if (FWD_EN && wv && (wr != '0)) begin
            if (wr == e.rs1)
                r.a = wd;
            if (!e.b_imm && (wr == e.rs2))
                r.b = wd;
        end
        return r;
    endfunction

    always_comb begin
        in_e = '{op: in_op, rs1: in_rs1, rs2: in_rs2, b_imm: in_b_imm,
                 rd: in_rd, a: in_a, b: in_b};
        in_f   = fwd(in_e,   wb_valid, wb_rd, wb_data);
        main_f = fwd(main_q, wb_valid, wb_rd, wb_data);
        skid_f = fwd(skid_q, wb_valid, wb_rd, wb_data);
    end

    assign in_ready = !skid_valid;
    assign accept   = in_valid && !skid_valid;
    assign fire     = main_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (!main_valid) begin
            if (accept) begin
                main_q     <= in_f;
                main_valid <= 1'b1;
            end
        end else if (fire) begin
            if (skid_valid) begin
                main_q     <= skid_f;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_q <= in_f;
            end else begin
                main_valid <= 1'b0;
            end
        end else begin
            main_q <= main_f;
            if (skid_valid) begin
                skid_q <= skid_f;
            end else if (accept) begin
                skid_q     <= in_f;
                skid_valid <= 1'b1;
            end
        end
    end

    assign out_valid = main_valid;
    assign alu_src_a = main_q.a;
    assign alu_src_b = main_q.b;
    assign alu_op    = main_q.op;
    assign out_rd    = main_q.rd;

endmodule

// File: tb/tb_alu_issue.sv
// Randomized and directed bench for alu_issue against an in-order queue model.
module tb_alu_issue;
    localparam int XLEN   = 32;
    localparam int RIDX_W = 5;

`ifdef ALU_ISSUE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              in_valid = 1'b0, in_ready;
    logic [2:0]        in_op = '0;
    logic [RIDX_W-1:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0;
    logic              in_b_imm = 1'b0;
    logic [XLEN-1:0]   in_a = '0, in_b = '0;
    logic              wb_valid = 1'b0;
    logic [RIDX_W-1:0] wb_rd = '0;
    logic [XLEN-1:0]   wb_data = '0;
    logic              out_valid, out_ready = 1'b0;
    logic [XLEN-1:0]   alu_src_a, alu_src_b;
    logic [2:0]        alu_op;
    logic [RIDX_W-1:0] out_rd;

    alu_issue #(.XLEN(XLEN), .RIDX_W(RIDX_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_b_imm(in_b_imm), .in_rd(in_rd),
        .in_a(in_a), .in_b(in_b),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .out_rd(out_rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  rs1, rs2, rd;
        logic        b_imm;
        logic [31:0] a, b;
    } op_t;

    op_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Writeback overrides a register operand unless it targets x0 or an immediate B.
    function automatic op_t apply_wb(input op_t e);
        op_t r = e;
        if (FWD && wb_valid && wb_rd != 0) begin
            if (wb_rd == e.rs1) r.a = wb_data;
            if (!e.b_imm && wb_rd == e.rs2) r.b = wb_data;
        end
        return r;
    endfunction

    task automatic compare_outputs();
        check("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
        check("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
        if (q.size() > 0) begin
            check("src_a", {32'd0, alu_src_a}, {32'd0, q[0].a});
            check("src_b", {32'd0, alu_src_b}, {32'd0, q[0].b});
            check("alu_op", {61'd0, alu_op}, {61'd0, q[0].op});
            check("out_rd", {59'd0, out_rd}, {59'd0, q[0].rd});
        end
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic tick();
        bit   do_fire, do_acc;
        op_t  n;
        compare_outputs();
        @(posedge clk);
        do_fire = (q.size() > 0) && out_ready;
        do_acc  = in_valid && (q.size() < 2);
        n = '{op: in_op, rs1: in_rs1, rs2: in_rs2, rd: in_rd, b_imm: in_b_imm, a: in_a, b: in_b};
        if (do_fire) void'(q.pop_front());
        foreach (q[i]) q[i] = apply_wb(q[i]);
        if (do_acc) q.push_back(apply_wb(n));
        @(negedge clk);
    endtask

    task automatic set_op(input logic v, input logic [2:0] op, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic bimm, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] b);
        in_valid = v; in_op = op; in_rs1 = rs1; in_rs2 = rs2;
        in_b_imm = bimm; in_rd = rd; in_a = a; in_b = b;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
        check({tag, "_bus"}, {alu_src_a, alu_src_b} | {61'd0, alu_op} | {59'd0, out_rd}, 64'd0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2 check_zero_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);

        // single op, one-cycle latency
        out_ready = 1'b1;
        set_op(1, 3'd0, 0, 0, 0, 3, 32'd5, 32'd7);
        tick();
        set_op(0, 0, 0, 0, 0, 0, 0, 0);
        check("t1_src_a", {32'd0, alu_src_a}, 64'd5);
        check("t1_src_b", {32'd0, alu_src_b}, 64'd7);
        check("t1_rd", {59'd0, out_rd}, 64'd3);
        tick();
        check("t1_drained", {63'd0, out_valid}, 64'd0);

        // stall fills main and skid
        out_ready = 1'b0;
        set_op(1, 3'd1, 0, 0, 0, 1, 32'd1, 32'd0);
        tick();
        set_op(1, 3'd2, 0, 0, 0, 2, 32'd2, 32'd0);
        tick();
        set_op(0, 0, 0, 0, 0, 0, 0, 0);
        check("t2_in_ready_low", {63'd0, in_ready}, 64'd0);
        check("t2_main_a", {32'd0, alu_src_a}, 64'd1);
        tick();
        out_ready = 1'b1;
        tick();
        check("t2_b_out", {32'd0, alu_src_a}, 64'd2);
        check("t2_in_ready_back", {63'd0, in_ready}, 64'd1);
        tick();
        tick();

        // back-to-back streaming
        for (int i = 0; i < 16; i++) begin
            set_op(1, 3'(i), 0, 0, 0, 5'(i), 32'(i), 32'(i + 100));
            tick();
        end
        set_op(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();

        // capture forwarding, hit and x0
        out_ready = 1'b0;
        set_op(1, 3'd0, 4, 0, 0, 1, 32'h11, 32'h0);
        wb_valid = 1; wb_rd = 4; wb_data = 32'hAB;
        tick();
        set_op(0, 0, 0, 0, 0, 0, 0, 0);
        wb_valid = 0;
        check("cap_fwd", {32'd0, alu_src_a}, FWD ? 64'hAB : 64'h11);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        set_op(1, 3'd0, 0, 0, 0, 1, 32'h11, 32'h0);
        wb_valid = 1; wb_rd = 0; wb_data = 32'hAB;
        tick();
        set_op(0, 0, 0, 0, 0, 0, 0, 0);
        wb_valid = 0;
        check("cap_x0", {32'd0, alu_src_a}, 64'h11);
        out_ready = 1'b1;
        tick();

        // held forwarding with and without immediate B
        for (int imm = 0; imm < 2; imm++) begin
            out_ready = 1'b0;
            set_op(1, 3'd3, 0, 6, imm[0], 2, 32'h0, 32'h1);
            tick();
            set_op(0, 0, 0, 0, 0, 0, 0, 0);
            wb_valid = 1; wb_rd = 6; wb_data = 32'h55;
            tick();
            wb_valid = 0;
            check(imm ? "held_imm" : "held_fwd", {32'd0, alu_src_b},
                  (FWD && imm == 0) ? 64'h55 : 64'h1);
            out_ready = 1'b1;
            tick();
        end

        // randomized traffic with frequent register collisions
        for (int c = 0; c < 2000; c++) begin
            set_op($urandom_range(0, 3) != 0, 3'($urandom), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom), $urandom, $urandom);
            wb_valid  = $urandom_range(0, 1) == 1;
            wb_rd     = 5'($urandom_range(0, 3));
            wb_data   = $urandom;
            out_ready = $urandom_range(0, 2) != 0;
            tick();
        end

        // async reset while both entries are full
        wb_valid = 0;
        out_ready = 1'b0;
        set_op(1, 3'd5, 0, 0, 0, 7, 32'hDEAD, 32'hBEEF);
        tick();
        tick();
        tick();
        set_op(0, 0, 0, 0, 0, 0, 0, 0);
        check("full_before_rst", {63'd0, in_ready}, 64'd0);
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("midrst");
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
